// File: rtl/oldland_assoc_cache_if.sv
// Bus bundle between a CPU, the set-associative cache and the backing memory.
//   CPU side    : c_access/c_addr/c_wr_en/c_wr_data/c_bytesel -> c_data/c_ack/c_error
//   Control     : ctrl_inval (flash-invalidate every line)
//   Memory side : m_access/m_wr_en/m_addr/m_wr_data/m_bytesel -> m_data/m_ack/m_error
// slave  : the cache's view (serves the CPU, masters the memory).
// master : the environment's view (CPU plus memory).
interface oldland_assoc_cache_if;
    logic        c_access;
    logic [29:0] c_addr;
    logic        c_wr_en;
    logic [31:0] c_wr_data;
    logic [3:0]  c_bytesel;
    logic [31:0] c_data;
    logic        c_ack;
    logic        c_error;
    logic        ctrl_inval;
    logic        m_access;
    logic        m_wr_en;
    logic [29:0] m_addr;
    logic [31:0] m_wr_data;
    logic [3:0]  m_bytesel;
    logic [31:0] m_data;
    logic        m_ack;
    logic        m_error;

    modport slave (
        input  c_access, c_addr, c_wr_en, c_wr_data, c_bytesel, ctrl_inval,
        input  m_data, m_ack, m_error,
        output c_data, c_ack, c_error,
        output m_access, m_wr_en, m_addr, m_wr_data, m_bytesel
    );

    modport master (
        output c_access, c_addr, c_wr_en, c_wr_data, c_bytesel, ctrl_inval,
        output m_data, m_ack, m_error,
        input  c_data, c_ack, c_error,
        input  m_access, m_wr_en, m_addr, m_wr_data, m_bytesel
    );
endinterface

// File: rtl/oldland_assoc_cache.sv
// Set-associative, write-through, no-write-allocate cache.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - oldland_assoc_cache_if.slave: CPU request/response, ctrl_inval,
//          and the memory request/response used for line fills and writes.
// Reads hit in the cycle after the request (COMPARE); misses fill a whole
// line from memory word by word, then acknowledge with the requested word.
module oldland_assoc_cache #(
    parameter int CACHE_SIZE      = 8192,
    parameter int CACHE_LINE_SIZE = 32,
    parameter int WAYS            = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    oldland_assoc_cache_if.slave  bus
);
    localparam int WORDS_PER_LINE = CACHE_LINE_SIZE / 4;
    localparam int OFFSET_BITS    = $clog2(WORDS_PER_LINE);
    localparam int SETS           = CACHE_SIZE / (CACHE_LINE_SIZE * WAYS);
    localparam int INDEX_BITS     = $clog2(SETS);
    localparam int LINE_BITS      = INDEX_BITS + OFFSET_BITS;
    localparam int TAG_BITS       = 30 - LINE_BITS;
    localparam int WAY_BITS       = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        COMPARE = 4'b0010,
        FILL    = 4'b0100,
        WRITE   = 4'b1000
    } state_t;

    state_t                 state_reg, state_next;
    logic [29:0]            addr_reg;
    logic                   wr_en_reg;
    logic [31:0]            wr_data_reg;
    logic [3:0]             bytesel_reg;
    logic [OFFSET_BITS-1:0] cnt_reg;
    logic [WAY_BITS-1:0]    rr_reg, victim_reg, hit_way_reg;
    logic                   victim_rr_reg, hit_reg, done_reg, err_reg;
    logic [31:0]            fill_word_reg;

    logic [TAG_BITS-1:0]    tag;
    logic [INDEX_BITS-1:0]  index;
    logic [OFFSET_BITS-1:0] offset;
    assign tag    = addr_reg[29 -: TAG_BITS];
    assign index  = addr_reg[OFFSET_BITS +: INDEX_BITS];
    assign offset = addr_reg[OFFSET_BITS-1:0];

    logic                   latch_req, fill_start, fill_beat, fill_last, write_ok;
    logic [LINE_BITS-1:0]   rd_addr, data_waddr;
    logic [31:0]            data_wdata;
    logic [3:0]             data_be;
    logic [WAYS-1:0]        data_we, tag_we, hit_vec, way_valid;
    logic [WAYS-1:0][31:0]  data_q;
    logic                   hit_any, victim_rr;
    logic [WAY_BITS-1:0]    hit_way, victim;
    logic [31:0]            hit_data;

    // The RAMs are read with the incoming CPU address on the edge a request
    // is accepted so that tag and data are ready in COMPARE.
    assign rd_addr    = latch_req ? bus.c_addr[LINE_BITS-1:0] : addr_reg[LINE_BITS-1:0];
    assign data_waddr = fill_beat ? {index, cnt_reg} : addr_reg[LINE_BITS-1:0];
    assign data_wdata = fill_beat ? bus.m_data : wr_data_reg;
    assign data_be    = fill_beat ? 4'hF : bytesel_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            logic [31:0]         data_mem [SETS*WORDS_PER_LINE];
            logic [TAG_BITS-1:0] tag_mem  [SETS];
            logic [31:0]         q_reg;
            logic [TAG_BITS-1:0] tag_q_reg;
            logic [SETS-1:0]     valid_reg;

            assign data_we[gi] = (fill_beat && victim_reg == WAY_BITS'(gi)) ||
                                 (write_ok && hit_reg && hit_way_reg == WAY_BITS'(gi));
            assign tag_we[gi]  = fill_last && victim_reg == WAY_BITS'(gi);

            always_ff @(posedge clk) begin
                if (data_we[gi]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (data_be[b])
                            data_mem[data_waddr][b*8 +: 8] <= data_wdata[b*8 +: 8];
                    end
                end
                q_reg <= data_mem[rd_addr];
                if (tag_we[gi])
                    tag_mem[index] <= tag;
                tag_q_reg <= tag_mem[rd_addr[LINE_BITS-1:OFFSET_BITS]];
            end

            // Invalidate wins over a completing fill; the victim is dropped
            // as soon as its fill starts so a partial line is never valid.
            always_ff @(posedge clk) begin
                if (rst || bus.ctrl_inval)
                    valid_reg <= '0;
                else if (tag_we[gi])
                    valid_reg[index] <= 1'b1;
                else if (fill_start && victim == WAY_BITS'(gi))
                    valid_reg[index] <= 1'b0;
            end

            assign data_q[gi]    = q_reg;
            assign way_valid[gi] = valid_reg[index];
            assign hit_vec[gi]   = valid_reg[index] && (tag_q_reg == tag);
        end
    endgenerate

    // Hit way and victim: first invalid way wins, else the round-robin pointer.
    always_comb begin
        hit_any   = 1'b0;
        hit_way   = '0;
        hit_data  = '0;
        victim    = rr_reg;
        victim_rr = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) begin
                hit_any  = 1'b1;
                hit_way  = WAY_BITS'(w);
                hit_data = data_q[w];
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                victim    = WAY_BITS'(w);
                victim_rr = 1'b0;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        bus.c_ack     = 1'b0;
        bus.c_error   = 1'b0;
        bus.c_data    = '0;
        bus.m_access  = 1'b0;
        bus.m_wr_en   = 1'b0;
        bus.m_addr    = '0;
        bus.m_wr_data = '0;
        bus.m_bytesel = '0;
        latch_req     = 1'b0;
        fill_start    = 1'b0;
        fill_beat     = 1'b0;
        fill_last     = 1'b0;
        write_ok      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.c_access) begin
                    latch_req  = 1'b1;
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (wr_en_reg) begin
                    state_next = WRITE;
                end else if (hit_any) begin
                    bus.c_ack  = 1'b1;
                    bus.c_data = hit_data;
                    latch_req  = bus.c_access;
                    state_next = bus.c_access ? COMPARE : IDLE;
                end else begin
                    fill_start = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                // done_reg marks the response cycle after the last beat or an error.
                if (done_reg) begin
                    bus.c_ack   = 1'b1;
                    bus.c_error = err_reg;
                    bus.c_data  = err_reg ? 32'h0 : fill_word_reg;
                    state_next  = IDLE;
                end else begin
                    bus.m_access = 1'b1;
                    bus.m_addr   = {tag, index, bus.m_ack ? cnt_reg + OFFSET_BITS'(1) : cnt_reg};
                    if (bus.m_ack && !bus.m_error) begin
                        fill_beat = 1'b1;
                        fill_last = (cnt_reg == OFFSET_BITS'(WORDS_PER_LINE - 1));
                    end
                end
            end
            WRITE: begin
                if (done_reg) begin
                    bus.c_ack   = 1'b1;
                    bus.c_error = err_reg;
                    state_next  = IDLE;
                end else begin
                    bus.m_access  = 1'b1;
                    bus.m_wr_en   = 1'b1;
                    bus.m_addr    = addr_reg;
                    bus.m_wr_data = wr_data_reg;
                    bus.m_bytesel = bytesel_reg;
                    write_ok      = bus.m_ack && !bus.m_error;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rr_reg    <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == COMPARE) begin
                cnt_reg  <= '0;
                done_reg <= 1'b0;
                err_reg  <= 1'b0;
            end
            if (fill_beat)
                cnt_reg <= cnt_reg + OFFSET_BITS'(1);
            if (fill_last) begin
                done_reg <= 1'b1;
                if (victim_rr_reg)
                    rr_reg <= (rr_reg == WAY_BITS'(WAYS - 1)) ? '0 : rr_reg + WAY_BITS'(1);
            end
            if ((state_reg == FILL || state_reg == WRITE) && !done_reg && bus.m_error) begin
                done_reg <= 1'b1;
                err_reg  <= 1'b1;
            end
            if (write_ok)
                done_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_req) begin
            addr_reg    <= bus.c_addr;
            wr_en_reg   <= bus.c_wr_en;
            wr_data_reg <= bus.c_wr_data;
            bytesel_reg <= bus.c_bytesel;
        end
        if (state_reg == COMPARE) begin
            hit_reg       <= hit_any;
            hit_way_reg   <= hit_way;
            victim_reg    <= victim;
            victim_rr_reg <= victim_rr;
        end
        if (fill_beat && cnt_reg == offset)
            fill_word_reg <= bus.m_data;
    end
endmodule
